// File: rtl/alu_seq_pkg.sv
// Shared codes, state encoding and command classification for alu_sequencer.
package alu_seq_pkg;

   localparam logic [3:0] ALU_NOP = 4'b0000;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_LDA = 4'b0011;
   localparam logic [3:0] ALU_CMA = 4'b1001;
   localparam logic [3:0] ALU_CME = 4'b1010;
   localparam logic [3:0] ALU_CIR = 4'b1011;
   localparam logic [3:0] ALU_CIL = 4'b1100;
   localparam logic [3:0] ALU_INP = 4'b1101;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_MEM_RD   = 2'd1;
   localparam logic [1:0] ST_INP_WAIT = 2'd2;
   localparam logic [1:0] ST_EXEC     = 2'd3;

   function automatic logic is_mem_op(input logic [3:0] code);
      return (code == ALU_AND) || (code == ALU_ADD) || (code == ALU_LDA);
   endfunction

   function automatic logic is_legal(input logic [3:0] code);
      case (code)
         ALU_AND, ALU_ADD, ALU_LDA, ALU_CMA, ALU_CME,
         ALU_CIR, ALU_CIL, ALU_INP: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle controller sequencing alu_unit for one accumulator instruction at a time.
// Optional memory-read watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TMO_W          = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_code,
   output logic       dr_rd_req,
   input  logic       dr_rd_ack,
   input  logic       inp_flag,
   output logic       inp_flag_clr,
   output logic [3:0] alu_code,
   input  logic       alu_ff_en,
   output logic       ac_ld,
   output logic       e_ld,
   output logic       done,
   output logic       illegal,
   output logic       timeout
);

   if ((TMO_W < 1) || ((2 ** TMO_W) <= TIMEOUT_CYCLES)) begin : g_tmo_w_check
      $error("TMO_W too narrow for TIMEOUT_CYCLES");
   end

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [3:0] code;
   logic       illegal_q;
   logic       accept;
   logic       exec;
   logic       expire;

   assign accept = cmd_valid && (state == ST_IDLE);
   assign exec   = (state == ST_EXEC);

`ifdef ALU_SEQ_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt;

   // Counter idles at zero outside MEM_RD, so every read starts a fresh count.
   always_ff @(posedge clk) begin
      if (reset || (state != ST_MEM_RD)) begin
         tmo_cnt <= '0;
      end else if (!dr_rd_ack) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   assign expire  = (state == ST_MEM_RD) && !dr_rd_ack
                    && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign timeout = expire;
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_mem_op(cmd_code))      state_nxt = ST_MEM_RD;
               else if (cmd_code == ALU_INP) state_nxt = ST_INP_WAIT;
               else if (is_legal(cmd_code))  state_nxt = ST_EXEC;
            end
         end
         // An ack arriving in the expiry cycle takes priority over the watchdog.
         ST_MEM_RD: begin
            if (dr_rd_ack)   state_nxt = ST_EXEC;
            else if (expire) state_nxt = ST_IDLE;
         end
         ST_INP_WAIT: begin
            if (inp_flag) state_nxt = ST_EXEC;
         end
         ST_EXEC:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         illegal_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         illegal_q <= accept && !is_legal(cmd_code);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) code <= cmd_code;
   end

   assign cmd_ready    = (state == ST_IDLE);
   assign dr_rd_req    = (state == ST_MEM_RD);
   assign alu_code     = exec ? code : ALU_NOP;
   assign ac_ld        = exec && (code != ALU_CME);
   assign e_ld         = exec && alu_ff_en;
   assign done         = exec;
   assign inp_flag_clr = exec && (code == ALU_INP);
   assign illegal      = illegal_q;

endmodule
